// File: rtl/pf_vf_mux_pkg.sv
// Shared PF/VF mux definitions.
// Field widths of the PCIe function identifiers and the routing-table entry
// that maps an AFU port index to the host function it is allowed to use.
package pf_vf_mux_pkg;

    localparam int PF_WIDTH    = 3;
    localparam int VF_WIDTH    = 11;
    localparam int PFVF_PORT_W = 8;

    typedef struct packed {
        logic [PF_WIDTH-1:0]    pf;
        logic [VF_WIDTH-1:0]    vf;
        logic                   vf_active;
        logic [PFVF_PORT_W-1:0] pfvf_port;
    } t_pfvf_rtable_entry;

endpackage

// File: rtl/pfvf_rsp_skid.sv
// Two-entry skid buffer for the merged response stream.
// An output register plus one overflow slot. in_ready depends only on the
// overflow slot being empty, so there is no combinational path from
// out_ready to in_ready, and a beat accepted in cycle N is visible on
// out_valid in cycle N+1. Data registers carry no reset.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   upstream handshake
//   in_data  [W]        upstream payload
//   out_valid/out_ready downstream handshake
//   out_data [W]        downstream payload (held while stalled)
module pfvf_rsp_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         vld_p1;
    logic         skid_vld_p1;
    logic [W-1:0] data_p1;
    logic [W-1:0] skid_data_p1;
    logic         in_fire;
    logic         load_out;

    assign in_ready  = !skid_vld_p1;
    assign in_fire   = in_valid && in_ready;
    // Output register may take a new beat when empty or being drained.
    assign load_out  = out_ready || !vld_p1;
    assign out_valid = vld_p1;
    assign out_data  = data_p1;

    // ---- stage p1: output register and overflow slot ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1      <= 1'b0;
            skid_vld_p1 <= 1'b0;
        end else if (load_out) begin
            if (skid_vld_p1) begin
                vld_p1      <= 1'b1;
                skid_vld_p1 <= 1'b0;
            end else begin
                vld_p1      <= in_fire;
            end
        end else if (in_fire) begin
            skid_vld_p1 <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (load_out) begin
            data_p1 <= skid_vld_p1 ? skid_data_p1 : in_data;
        end else if (in_fire) begin
            skid_data_p1 <= in_data;
        end
    end

endmodule

// File: rtl/pfvf_rsp_arb.sv
// Packet-granular round-robin merge of AFU response streams toward the host.
// A port is granted for a whole packet; every beat is stamped with the
// PF/VF taken from the routing table entry owned by that port, and the
// function the port claimed on its first beat is checked against the table.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   in_tvalid/in_tready [NUM_PORT]  per-port handshake
//   in_tdata [NUM_PORT][DATA_W]     per-port beat data
//   in_tlast [NUM_PORT]             last beat of packet
//   in_pf/in_vf/in_vf_active        function claimed by each port
//   out_tvalid/out_tready           host-side handshake
//   out_tdata/out_tlast             merged beat
//   out_pf/out_vf/out_vf_active     stamped function from the routing table
//   out_port [PORT_W]               source port of the beat
//   err_mismatch                    pulse when a claimed function disagrees
//   err_cnt [16]                    saturating mismatch count
module pfvf_rsp_arb
    import pf_vf_mux_pkg::*;
#(
    parameter int NUM_PORT = 4,
    parameter int DATA_W   = 512,
    parameter t_pfvf_rtable_entry [NUM_PORT-1:0] RTABLE = '0,
    localparam int PORT_W  = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_PORT-1:0]                in_tvalid,
    output logic [NUM_PORT-1:0]                in_tready,
    input  logic [NUM_PORT-1:0][DATA_W-1:0]    in_tdata,
    input  logic [NUM_PORT-1:0]                in_tlast,
    input  logic [NUM_PORT-1:0][PF_WIDTH-1:0]  in_pf,
    input  logic [NUM_PORT-1:0][VF_WIDTH-1:0]  in_vf,
    input  logic [NUM_PORT-1:0]                in_vf_active,
    output logic                               out_tvalid,
    input  logic                               out_tready,
    output logic [DATA_W-1:0]                  out_tdata,
    output logic                               out_tlast,
    output logic [PF_WIDTH-1:0]                out_pf,
    output logic [VF_WIDTH-1:0]                out_vf,
    output logic                               out_vf_active,
    output logic [PORT_W-1:0]                  out_port,
    output logic                               err_mismatch,
    output logic [15:0]                        err_cnt
);

    localparam int STAMP_W = PF_WIDTH + VF_WIDTH + 1;
    localparam int PAY_W   = DATA_W + 1 + STAMP_W + PORT_W;

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [PORT_W-1:0]   last_grant;
    logic [PORT_W-1:0]   lock_port;
    logic [PORT_W-1:0]   rr_port;
    logic                rr_found;
    logic [PORT_W-1:0]   cur_port;
    logic                active;
    logic                skid_in_valid;
    logic                skid_in_ready;
    logic                grant_ok;
    logic                fire;
    logic                first_fire;
    logic [STAMP_W-1:0]  stamp;
    logic [PF_WIDTH-1:0] ent_pf;
    logic [VF_WIDTH-1:0] ent_vf;
    logic                ent_va;
    logic                mismatch;
    logic [PAY_W-1:0]    skid_in_data;
    logic [PAY_W-1:0]    skid_out_data;

    // Lowest-index table entry whose pfvf_port names the port wins; an
    // unclaimed port is stamped with all-zero function fields.
    function automatic logic [STAMP_W-1:0] rtable_stamp(input logic [PORT_W-1:0] port);
        logic [STAMP_W-1:0] s;
        s = '0;
        for (int i = NUM_PORT - 1; i >= 0; i--) begin
            if (int'(RTABLE[i].pfvf_port) == int'(port)) begin
                s = {RTABLE[i].pf, RTABLE[i].vf, RTABLE[i].vf_active};
            end
        end
        return s;
    endfunction

    // Round-robin search starting one past the previous winner.
    always_comb begin
        int idx;
        idx      = 0;
        rr_found = 1'b0;
        rr_port  = '0;
        for (int k = 0; k < NUM_PORT; k++) begin
            idx = int'(last_grant) + 1 + k;
            if (idx >= NUM_PORT) begin
                idx = idx - NUM_PORT;
            end
            if (!rr_found && in_tvalid[idx]) begin
                rr_found = 1'b1;
                rr_port  = PORT_W'(idx);
            end
        end
    end

    assign cur_port      = (state == ST_LOCKED) ? lock_port : rr_port;
    assign active        = (state == ST_LOCKED) || rr_found;
    assign grant_ok      = active && skid_in_ready && rst_n;
    assign in_tready     = grant_ok ? (NUM_PORT'(1) << cur_port) : '0;
    assign skid_in_valid = active && rst_n && in_tvalid[cur_port];
    assign fire          = skid_in_valid && skid_in_ready;
    assign first_fire    = fire && (state == ST_IDLE);

    assign stamp                  = rtable_stamp(cur_port);
    assign {ent_pf, ent_vf, ent_va} = stamp;

    // vf only matters when both sides say the VF is active.
    assign mismatch     = (in_pf[cur_port] != ent_pf)
                       || (in_vf_active[cur_port] != ent_va)
                       || (in_vf_active[cur_port] && ent_va && (in_vf[cur_port] != ent_vf));
    assign err_mismatch = first_fire && mismatch;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (fire && !in_tlast[cur_port]) state_nxt = ST_LOCKED;
            ST_LOCKED: if (fire && in_tlast[cur_port])  state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // ---- stage p0: arbitration state and error counter ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            last_grant <= PORT_W'(NUM_PORT - 1);
            lock_port  <= '0;
            err_cnt    <= '0;
        end else begin
            state <= state_nxt;
            if (first_fire) begin
                last_grant <= rr_port;
                lock_port  <= rr_port;
            end
            if (err_mismatch && (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end

    assign skid_in_data = {in_tdata[cur_port], in_tlast[cur_port], stamp, cur_port};

    // ---- stage p1: output skid buffer ----
    pfvf_rsp_skid #(
        .W (PAY_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (skid_in_valid),
        .in_ready  (skid_in_ready),
        .in_data   (skid_in_data),
        .out_valid (out_tvalid),
        .out_ready (out_tready),
        .out_data  (skid_out_data)
    );

    assign {out_tdata, out_tlast, out_pf, out_vf, out_vf_active, out_port} = skid_out_data;

endmodule

// File: tb/tb_pfvf_rsp_arb.sv
module tb_pfvf_rsp_arb;
    import pf_vf_mux_pkg::*;

    localparam int NP = 4;
    localparam int DW = 32;

    // Table entry index k describes port 3-k, so the lookup by pfvf_port matters.
    localparam t_pfvf_rtable_entry [NP-1:0] TB_RTABLE = {
        t_pfvf_rtable_entry'{pf: 3'd1, vf: 11'd3, vf_active: 1'b0, pfvf_port: 8'd0},
        t_pfvf_rtable_entry'{pf: 3'd2, vf: 11'd7, vf_active: 1'b1, pfvf_port: 8'd1},
        t_pfvf_rtable_entry'{pf: 3'd0, vf: 11'd5, vf_active: 1'b1, pfvf_port: 8'd2},
        t_pfvf_rtable_entry'{pf: 3'd3, vf: 11'd0, vf_active: 1'b0, pfvf_port: 8'd3}
    };

    // Same table, indexed directly by port.
    localparam logic [PF_WIDTH-1:0] T_PF [NP] = '{3'd1, 3'd2, 3'd0, 3'd3};
    localparam logic [VF_WIDTH-1:0] T_VF [NP] = '{11'd3, 11'd7, 11'd5, 11'd0};
    localparam logic                T_VA [NP] = '{1'b0, 1'b1, 1'b1, 1'b0};

    logic                          clk = 1'b0;
    logic                          rst_n;
    logic [NP-1:0]                 in_tvalid;
    logic [NP-1:0]                 in_tready;
    logic [NP-1:0][DW-1:0]         in_tdata;
    logic [NP-1:0]                 in_tlast;
    logic [NP-1:0][PF_WIDTH-1:0]   in_pf;
    logic [NP-1:0][VF_WIDTH-1:0]   in_vf;
    logic [NP-1:0]                 in_vf_active;
    logic                          out_tvalid;
    logic                          out_tready;
    logic [DW-1:0]                 out_tdata;
    logic                          out_tlast;
    logic [PF_WIDTH-1:0]           out_pf;
    logic [VF_WIDTH-1:0]           out_vf;
    logic                          out_vf_active;
    logic [1:0]                    out_port;
    logic                          err_mismatch;
    logic [15:0]                   err_cnt;

    always #5 clk = ~clk;

    pfvf_rsp_arb #(
        .NUM_PORT (NP),
        .DATA_W   (DW),
        .RTABLE   (TB_RTABLE)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_tvalid     (in_tvalid),
        .in_tready     (in_tready),
        .in_tdata      (in_tdata),
        .in_tlast      (in_tlast),
        .in_pf         (in_pf),
        .in_vf         (in_vf),
        .in_vf_active  (in_vf_active),
        .out_tvalid    (out_tvalid),
        .out_tready    (out_tready),
        .out_tdata     (out_tdata),
        .out_tlast     (out_tlast),
        .out_pf        (out_pf),
        .out_vf        (out_vf),
        .out_vf_active (out_vf_active),
        .out_port      (out_port),
        .err_mismatch  (err_mismatch),
        .err_cnt       (err_cnt)
    );

    typedef struct {
        logic [DW-1:0]       d;
        bit                  l;
        logic [PF_WIDTH-1:0] pf;
        logic [VF_WIDTH-1:0] vf;
        bit                  va;
    } beat_t;

    typedef struct {
        logic [DW-1:0]       d;
        bit                  l;
        logic [PF_WIDTH-1:0] pf;
        logic [VF_WIDTH-1:0] vf;
        bit                  va;
        int                  port;
    } obeat_t;

    beat_t  stim [NP][$];
    obeat_t mfifo[$];
    obeat_t seen[$];

    // Reference state: who won last, whether a packet is in progress, the
    // two-deep output buffer contents and the expected error count.
    int  mlast;
    bit  mlocked;
    int  mport;
    int  merr;

    bit  rst_cmd;
    int  ordy_mode;
    bit  vld_rand;
    int  total;
    int  bad;
    int  pulse_cnt;
    int  last_drain;

    logic [NP-1:0] samp_ready;
    logic          samp_ovld;
    logic [DW-1:0] samp_odata;
    logic [15:0]   samp_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad < 60) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_pkt(input int p, input int n, input logic [DW-1:0] base,
                           input logic [PF_WIDTH-1:0] pf, input logic [VF_WIDTH-1:0] vf, input bit va);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.d  = base + DW'(i);
            b.l  = (i == n - 1);
            b.pf = pf;
            b.vf = vf;
            b.va = va;
            stim[p].push_back(b);
        end
    endtask

    // Claimed function agrees with the table; vf is random when inactive.
    task automatic add_good(input int p, input int n, input logic [DW-1:0] base);
        logic [VF_WIDTH-1:0] vf;
        vf = T_VA[p] ? T_VF[p] : VF_WIDTH'($urandom);
        add_pkt(p, n, base, T_PF[p], vf, T_VA[p]);
    endtask

    task automatic add_bad(input int p, input int n, input logic [DW-1:0] base);
        add_pkt(p, n, base, T_PF[p] ^ 3'd1, T_VF[p], T_VA[p]);
    endtask

    function automatic bit mismatch_of(input beat_t b, input int p);
        return (b.pf != T_PF[p]) || (b.va != T_VA[p]) || (b.va && T_VA[p] && (b.vf != T_VF[p]));
    endfunction

    function automatic bit busy();
        bit r;
        r = (mfifo.size() > 0);
        for (int p = 0; p < NP; p++) if (stim[p].size() > 0) r = 1'b1;
        return r;
    endfunction

    task automatic step();
        int            cand;
        int            idx;
        bit            act;
        bit            space;
        bit            fire;
        bit            mism;
        bit            ordy;
        logic [NP-1:0] exp_ready;
        beat_t         b;
        obeat_t        o;
        obeat_t        s;

        @(negedge clk);
        rst_n = rst_cmd;
        for (int p = 0; p < NP; p++) begin
            if (stim[p].size() > 0 && (!vld_rand || $urandom_range(3) != 0)) begin
                b = stim[p][0];
                in_tvalid[p]    = 1'b1;
                in_tdata[p]     = b.d;
                in_tlast[p]     = b.l;
                in_pf[p]        = b.pf;
                in_vf[p]        = b.vf;
                in_vf_active[p] = b.va;
            end else begin
                in_tvalid[p]    = 1'b0;
                in_tdata[p]     = DW'($urandom);
                in_tlast[p]     = 1'($urandom);
                in_pf[p]        = PF_WIDTH'($urandom);
                in_vf[p]        = VF_WIDTH'($urandom);
                in_vf_active[p] = 1'($urandom);
            end
        end
        ordy = (ordy_mode == 1) ? 1'b1 : (ordy_mode == 2) ? ($urandom_range(3) != 0) : 1'b0;
        out_tready = ordy;
        #1;

        space = rst_cmd && (mfifo.size() < 2);
        act   = 1'b0;
        cand  = 0;
        if (mlocked) begin
            act  = 1'b1;
            cand = mport;
        end else begin
            for (int k = 0; k < NP; k++) begin
                idx = (mlast + 1 + k) % NP;
                if (!act && in_tvalid[idx]) begin
                    act  = 1'b1;
                    cand = idx;
                end
            end
        end
        exp_ready = (act && space) ? (NP'(1) << cand) : '0;
        fire      = act && space && in_tvalid[cand];
        mism      = 1'b0;
        if (fire) begin
            b    = stim[cand][0];
            mism = !mlocked && mismatch_of(b, cand);
        end

        chk("in_tready", 64'(in_tready), 64'(exp_ready));
        chk("out_tvalid", 64'(out_tvalid), 64'(mfifo.size() > 0));
        if (mfifo.size() > 0) begin
            o = mfifo[0];
            chk("out_tdata", 64'(out_tdata), 64'(o.d));
            chk("out_tlast", 64'(out_tlast), 64'(o.l));
            chk("out_pf", 64'(out_pf), 64'(o.pf));
            chk("out_vf", 64'(out_vf), 64'(o.vf));
            chk("out_vf_active", 64'(out_vf_active), 64'(o.va));
            chk("out_port", 64'(out_port), 64'(o.port));
        end
        chk("err_mismatch", 64'(err_mismatch), 64'(mism));
        chk("err_cnt", 64'(err_cnt), 64'(merr));

        samp_ready = in_tready;
        samp_ovld  = out_tvalid;
        samp_odata = out_tdata;
        samp_err   = err_cnt;
        if (out_tvalid && ordy) begin
            s.d    = out_tdata;
            s.l    = out_tlast;
            s.pf   = out_pf;
            s.vf   = out_vf;
            s.va   = out_vf_active;
            s.port = int'(out_port);
            seen.push_back(s);
        end
        if (err_mismatch) pulse_cnt++;

        @(posedge clk);
        if (!rst_cmd) begin
            mlocked = 1'b0;
            mlast   = NP - 1;
            mport   = 0;
            merr    = 0;
            mfifo.delete();
            for (int p = 0; p < NP; p++) stim[p].delete();
        end else begin
            if (mfifo.size() > 0 && ordy) void'(mfifo.pop_front());
            if (fire) begin
                b      = stim[cand].pop_front();
                o.d    = b.d;
                o.l    = b.l;
                o.pf   = T_PF[cand];
                o.vf   = T_VF[cand];
                o.va   = T_VA[cand];
                o.port = cand;
                mfifo.push_back(o);
                if (!mlocked) begin
                    mlast   = cand;
                    mport   = cand;
                    mlocked = !b.l;
                end else if (b.l) begin
                    mlocked = 1'b0;
                end
                if (mism && merr < 65535) merr++;
            end
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (busy() && n < budget) begin
            step();
            n++;
        end
        last_drain = n;
        if (busy()) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: still busy after %0d cycles, required idle", budget);
        end
    endtask

    initial begin
        int p;
        total = 0; bad = 0; pulse_cnt = 0; last_drain = 0;
        mlast = NP - 1; mlocked = 1'b0; mport = 0; merr = 0;
        rst_cmd = 1'b0; ordy_mode = 1; vld_rand = 1'b0;
        rst_n = 1'b0; out_tready = 1'b0;
        in_tvalid = '0; in_tdata = '0; in_tlast = '0;
        in_pf = '0; in_vf = '0; in_vf_active = '0;

        // Reset state
        repeat (3) step();
        chk("rst_in_tready", 64'(samp_ready), 64'(0));
        chk("rst_out_tvalid", 64'(samp_ovld), 64'(0));
        chk("rst_err_cnt", 64'(samp_err), 64'(0));
        rst_cmd = 1'b1;

        // All ports busy with 2-beat packets: whole packets in order 0,1,2,3,0,...
        seen.delete();
        for (int r = 0; r < 2; r++)
            for (int q = 0; q < NP; q++) add_good(q, 2, 32'h1000 + DW'(r * 256 + q * 16));
        drain(100);
        chk("rr_count", 64'(seen.size()), 64'(16));
        for (int i = 0; i < 16 && i < seen.size(); i++) begin
            chk("rr_order", 64'(seen[i].port), 64'((i / 2) % 4));
            chk("rr_data", 64'(seen[i].d), 64'(32'h1000 + (i / 8) * 256 + ((i / 2) % 4) * 16 + (i % 2)));
        end

        // Port 2 claims pf=1, table says pf=0 vf=5 active
        seen.delete(); pulse_cnt = 0;
        add_pkt(2, 2, 32'h2000, 3'd1, 11'd5, 1'b1);
        drain(20);
        chk("mis_pulses", 64'(pulse_cnt), 64'(1));
        chk("mis_err_cnt", 64'(samp_err), 64'(1));
        chk("mis_count", 64'(seen.size()), 64'(2));
        if (seen.size() > 0) begin
            chk("mis_pf", 64'(seen[0].pf), 64'(0));
            chk("mis_vf", 64'(seen[0].vf), 64'(5));
            chk("mis_va", 64'(seen[0].va), 64'(1));
            chk("mis_port", 64'(seen[0].port), 64'(2));
        end

        // Host stalls 10 cycles during a 4-beat packet
        seen.delete(); ordy_mode = 0;
        add_good(3, 4, 32'h30A0);
        repeat (10) step();
        chk("stall_in_tready", 64'(samp_ready), 64'(0));
        chk("stall_out_tvalid", 64'(samp_ovld), 64'(1));
        chk("stall_out_tdata", 64'(samp_odata), 64'(32'h30A0));
        ordy_mode = 1;
        drain(20);
        chk("stall_count", 64'(seen.size()), 64'(4));
        for (int i = 0; i < 4 && i < seen.size(); i++) begin
            chk("stall_data", 64'(seen[i].d), 64'(32'h30A0 + i));
            chk("stall_last", 64'(seen[i].l), 64'(i == 3));
        end

        // Single-beat packets on port 1 only
        seen.delete();
        for (int i = 0; i < 8; i++) add_good(1, 1, 32'h4000 + DW'(i));
        drain(40);
        chk("single_count", 64'(seen.size()), 64'(8));
        for (int i = 0; i < seen.size(); i++) chk("single_port", 64'(seen[i].port), 64'(1));
        chk("single_rate", 64'(last_drain <= 18), 64'(1));

        // Reset in the middle of a port-0 packet
        add_good(0, 4, 32'h5000);
        step(); step();
        rst_cmd = 1'b0;
        step(); step();
        chk("midrst_out_tvalid", 64'(samp_ovld), 64'(0));
        chk("midrst_err_cnt", 64'(samp_err), 64'(0));
        rst_cmd = 1'b1;
        seen.delete();
        for (int q = 0; q < NP; q++) add_good(q, 2, 32'h6000 + DW'(q * 16));
        step();
        chk("postrst_grant", 64'(samp_ready), 64'(4'b0001));
        drain(60);
        if (seen.size() > 0) begin
            chk("postrst_first_port", 64'(seen[0].port), 64'(0));
            chk("postrst_first_data", 64'(seen[0].d), 64'(32'h6000));
        end else begin
            chk("postrst_count", 64'(seen.size()), 64'(8));
        end

        // Randomized traffic, backpressure and one reset in the middle
        ordy_mode = 2; vld_rand = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(2) == 0) begin
                p = $urandom_range(NP - 1);
                if (stim[p].size() < 8) begin
                    if ($urandom_range(4) == 0) add_bad(p, $urandom_range(1, 4), DW'($urandom));
                    else                        add_good(p, $urandom_range(1, 4), DW'($urandom));
                end
            end
            rst_cmd = !(c >= 1500 && c < 1502);
            step();
        end
        rst_cmd = 1'b1; vld_rand = 1'b0; ordy_mode = 1;
        drain(500);

        // Saturate the error counter
        for (int i = 0; i < 65540; i++) add_bad(0, 1, DW'(i));
        drain(70000);
        chk("err_cnt_sat", 64'(samp_err), 64'(16'hFFFF));
        for (int i = 0; i < 3; i++) add_bad(2, 1, DW'(i));
        drain(20);
        chk("err_cnt_hold", 64'(samp_err), 64'(16'hFFFF));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
